// File: rtl/memory_arbiter_if.sv
// Datapath request/response and shared RAM port signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the datapath/RAM environment.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        merr;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Registered, timeout-protected arbiter putting instruction and data requests
// onto one shared RAM port; completions are reported as one-cycle hit pulses.
module memory_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input logic              CLK,
  input logic              RST,
  memory_arbiter_if.slave  bus
);
  localparam int unsigned   CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [1:0]    RS_ACCESS = 2'd2;
  localparam logic [1:0]    RS_ERROR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_was_data_q, last_was_data_d;
  logic          wr_q, wr_d;
  logic [31:0]   ramaddr_q, ramaddr_d;
  logic [31:0]   ramstore_q, ramstore_d;
  logic          ramren_q, ramren_d;
  logic          ramwen_q, ramwen_d;
  logic          ihit_q, ihit_d;
  logic          dhit_q, dhit_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic          merr_q, merr_d;
  logic          access_s;
  logic          abort_s;
  logic [31:0]   rsp_s;

  // Next-state, grant and response computation for every flop.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_was_data_d = last_was_data_q;
    wr_d            = wr_q;
    ramaddr_d       = ramaddr_q;
    ramstore_d      = ramstore_q;
    ramren_d        = ramren_q;
    ramwen_d        = ramwen_q;
    ihit_d          = 1'b0;
    dhit_d          = 1'b0;
    iload_d         = 32'h0000_0000;
    dload_d         = 32'h0000_0000;
    merr_d          = merr_q;

    access_s = (bus.ramstate == RS_ACCESS);
    abort_s  = !access_s && ((bus.ramstate == RS_ERROR) || (cnt_q == CNT_LIMIT));
    if (access_s) begin
      rsp_s = wr_q ? 32'h0000_0000 : bus.ramload;
    end else begin
      rsp_s = ERR_WORD;
    end

    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        // A pending fetch right after a data service wins once, so data cannot starve it.
        if ((bus.dREN || bus.dWEN) && !(bus.iREN && last_was_data_q)) begin
          state_d    = DACC;
          ramaddr_d  = bus.daddr;
          ramstore_d = bus.dstore;
          wr_d       = bus.dWEN;
          ramwen_d   = bus.dWEN;
          ramren_d   = !bus.dWEN;
        end else if (bus.iREN) begin
          state_d    = IACC;
          ramaddr_d  = bus.iaddr;
          ramstore_d = 32'h0000_0000;
          wr_d       = 1'b0;
          ramwen_d   = 1'b0;
          ramren_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DACC, IACC: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1'b1);
        if (access_s || abort_s) begin
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          merr_d   = merr_q | abort_s;
          if (state_q == DACC) begin
            state_d = DRESP;
            dhit_d  = 1'b1;
            dload_d = rsp_s;
          end else begin
            state_d = IRESP;
            ihit_d  = 1'b1;
            iload_d = rsp_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      DRESP: begin
        cnt_d           = {CW{1'b0}};
        ramren_d        = 1'b0;
        ramwen_d        = 1'b0;
        last_was_data_d = 1'b1;
        state_d         = IDLE;
      end
      IRESP: begin
        cnt_d           = {CW{1'b0}};
        ramren_d        = 1'b0;
        ramwen_d        = 1'b0;
        last_was_data_d = 1'b0;
        state_d         = IDLE;
      end
      default: begin
        cnt_d    = {CW{1'b0}};
        ramren_d = 1'b0;
        ramwen_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      cnt_q           <= {CW{1'b0}};
      last_was_data_q <= 1'b0;
      wr_q            <= 1'b0;
      ramaddr_q       <= 32'h0000_0000;
      ramstore_q      <= 32'h0000_0000;
      ramren_q        <= 1'b0;
      ramwen_q        <= 1'b0;
      ihit_q          <= 1'b0;
      dhit_q          <= 1'b0;
      iload_q         <= 32'h0000_0000;
      dload_q         <= 32'h0000_0000;
      merr_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_was_data_q <= last_was_data_d;
      wr_q            <= wr_d;
      ramaddr_q       <= ramaddr_d;
      ramstore_q      <= ramstore_d;
      ramren_q        <= ramren_d;
      ramwen_q        <= ramwen_d;
      ihit_q          <= ihit_d;
      dhit_q          <= dhit_d;
      iload_q         <= iload_d;
      dload_q         <= dload_d;
      merr_q          <= merr_d;
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.iload    = iload_q;
  assign bus.dhit     = dhit_q;
  assign bus.dload    = dload_q;
  assign bus.merr     = merr_q;
  assign bus.ramREN   = ramren_q;
  assign bus.ramWEN   = ramwen_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed requests push expected hits and
// RAM accesses; a monitor pops and compares them as the DUT presents them.
module tb_memory_arbiter;
  logic CLK;
  logic RST;
  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT(64), .ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] load;
    int          cyc;
  } hit_t;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
    int          len;
  } acc_t;

  hit_t        hq[$];
  acc_t        aq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cycle = 1;
  bit          ram_err = 1'b0;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_hit(input bit d, input logic [31:0] ld, input int c);
    hq.push_back('{d, ld, c});
  endtask

  task automatic exp_acc(input bit w, input logic [31:0] a, input logic [31:0] s, input int l);
    aq.push_back('{w, a, s, l});
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // RAM model: BUSY until the acc_cycle-th enabled cycle, then ACCESS (0 = never).
  initial begin
    int k;
    k = 0;
    bus.ramstate = 2'd0;
    bus.ramload  = 32'h0;
    forever begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        k++;
        if (bus.ramWEN && k == 1) mem[bus.ramaddr] = bus.ramstore;
        if (ram_err) bus.ramstate = 2'd3;
        else if (acc_cycle != 0 && k >= acc_cycle) bus.ramstate = 2'd2;
        else bus.ramstate = 2'd1;
        bus.ramload = mem.exists(bus.ramaddr) ? mem[bus.ramaddr] : 32'h0;
      end else begin
        k = 0;
        bus.ramstate = 2'd0;
        bus.ramload  = 32'h0;
      end
    end
  end

  // Monitor: pops expected hits and RAM accesses as the DUT presents them.
  initial begin
    hit_t h;
    acc_t cur;
    bit   en;
    bit   en_prev;
    int   run;
    en_prev = 1'b0;
    run = 0;
    cur = '{1'b0, 32'h0, 32'h0, 0};
    forever begin
      @(negedge CLK);
      chk("hit_overlap", 32'(bus.ihit & bus.dhit), 32'd0);
      chk("enable_overlap", 32'(bus.ramREN & bus.ramWEN), 32'd0);
      if (bus.ihit || bus.dhit) begin
        if (hq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_hit: got ihit=%0b dhit=%0b expected none (cycle %0d)",
                   bus.ihit, bus.dhit, cyc);
        end else begin
          h = hq.pop_front();
          chk("hit_kind", 32'(bus.dhit), 32'(h.is_d));
          chk("hit_load", h.is_d ? bus.dload : bus.iload, h.load);
          if (h.cyc != 0) chk("hit_cycle", 32'(cyc), 32'(h.cyc));
        end
      end
      en = bus.ramREN || bus.ramWEN;
      if (en && !en_prev) begin
        run = 0;
        if (aq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_access: got addr 0x%08h expected none", bus.ramaddr);
          cur = '{1'b0, 32'h0, 32'h0, 0};
        end else begin
          cur = aq.pop_front();
          chk("acc_wen", 32'(bus.ramWEN), 32'(cur.wen));
          chk("acc_addr", bus.ramaddr, cur.addr);
          if (cur.wen) chk("acc_store", bus.ramstore, cur.store);
        end
      end
      if (en) run++;
      if (!en && en_prev && cur.len != 0) chk("acc_len", 32'(run), 32'(cur.len));
      en_prev = en;
    end
  end

  // Holds requests until their hits arrive, then leaves the DUT back in IDLE.
  task automatic service(input int nd, input int ni, input bit drd, input bit dwr, input int budget);
    int dn;
    int inn;
    int t;
    dn = nd;
    inn = ni;
    t = 0;
    bus.dREN = drd && (dn > 0);
    bus.dWEN = dwr && (dn > 0);
    bus.iREN = (inn > 0);
    while ((dn > 0 || inn > 0) && t < budget) begin
      @(negedge CLK);
      t++;
      if (bus.dhit) dn--;
      if (bus.ihit) inn--;
      bus.dREN = drd && (dn > 0);
      bus.dWEN = dwr && (dn > 0);
      bus.iREN = (inn > 0);
    end
    chk("service_done", 32'(dn + inn), 32'd0);
    @(negedge CLK);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bus.iREN = 1'b0;
    bus.iaddr = 32'h0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    bus.daddr = 32'h0;
    bus.dstore = 32'h0;
    mem[32'h40] = 32'h12345678;
    mem[32'h0]  = 32'h00000013;
    mem[32'h48] = 32'hA5A50048;
    repeat (2) @(negedge CLK);
    chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_dhit", 32'(bus.dhit), 32'd0);
    chk("rst_iload", bus.iload, 32'h0);
    chk("rst_dload", bus.dload, 32'h0);
    chk("rst_merr", 32'(bus.merr), 32'd0);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    RST = 1'b0;

    // Data read, ACCESS on the 2nd RAM cycle.
    acc_cycle = 2;
    bus.daddr = 32'h40;
    exp_hit(1'b1, 32'h12345678, cyc + 3);
    exp_acc(1'b0, 32'h40, 32'h0, 2);
    service(1, 0, 1'b1, 1'b0, 20);

    // Simultaneous write and fetch: write first, then fetch.
    pulse_reset();
    acc_cycle = 1;
    bus.iaddr = 32'h0;
    bus.daddr = 32'h80;
    bus.dstore = 32'h0000CAFE;
    exp_hit(1'b1, 32'h0, cyc + 2);
    exp_hit(1'b0, 32'h00000013, cyc + 5);
    exp_acc(1'b1, 32'h80, 32'h0000CAFE, 1);
    exp_acc(1'b0, 32'h0, 32'h0, 1);
    service(1, 1, 1'b0, 1'b1, 30);

    // Both held: grants alternate D, I, D, I.
    bus.daddr = 32'h40;
    exp_hit(1'b1, 32'h12345678, cyc + 2);
    exp_hit(1'b0, 32'h00000013, cyc + 5);
    exp_hit(1'b1, 32'h12345678, cyc + 8);
    exp_hit(1'b0, 32'h00000013, cyc + 11);
    exp_acc(1'b0, 32'h40, 32'h0, 1);
    exp_acc(1'b0, 32'h0, 32'h0, 1);
    exp_acc(1'b0, 32'h40, 32'h0, 1);
    exp_acc(1'b0, 32'h0, 32'h0, 1);
    service(2, 2, 1'b1, 1'b0, 60);
    chk("merr_before_error", 32'(bus.merr), 32'd0);

    // RAM ERROR on a fetch.
    ram_err = 1'b1;
    bus.iaddr = 32'h4;
    exp_hit(1'b0, 32'hBAD1BAD1, cyc + 2);
    exp_acc(1'b0, 32'h4, 32'h0, 1);
    service(0, 1, 1'b0, 1'b0, 20);
    ram_err = 1'b0;
    chk("merr_set", 32'(bus.merr), 32'd1);

    // Read back the earlier write; merr stays set.
    bus.daddr = 32'h80;
    exp_hit(1'b1, 32'h0000CAFE, cyc + 2);
    exp_acc(1'b0, 32'h80, 32'h0, 1);
    service(1, 0, 1'b1, 1'b0, 20);
    chk("merr_sticky", 32'(bus.merr), 32'd1);

    // dREN and dWEN together: a write returning zero.
    bus.daddr = 32'h90;
    bus.dstore = 32'h55AA55AA;
    exp_hit(1'b1, 32'h0, cyc + 2);
    exp_acc(1'b1, 32'h90, 32'h55AA55AA, 1);
    service(1, 0, 1'b1, 1'b1, 20);

    // RAM never answers: timeout after 64 cycles.
    acc_cycle = 0;
    bus.daddr = 32'h44;
    exp_hit(1'b1, 32'hBAD1BAD1, cyc + 65);
    exp_acc(1'b0, 32'h44, 32'h0, 64);
    service(1, 0, 1'b1, 1'b0, 100);

    // Reset in the middle of a stalled access.
    bus.daddr = 32'h48;
    exp_acc(1'b0, 32'h48, 32'h0, 0);
    bus.dREN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk("midrst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("midrst_dhit", 32'(bus.dhit), 32'd0);
    chk("midrst_merr", 32'(bus.merr), 32'd0);
    chk("midrst_dload", bus.dload, 32'h0);
    RST = 1'b0;
    acc_cycle = 1;
    exp_hit(1'b1, 32'hA5A50048, cyc + 2);
    exp_acc(1'b0, 32'h48, 32'h0, 1);
    service(1, 0, 1'b1, 1'b0, 20);

    // Address changes during the access are ignored.
    acc_cycle = 4;
    bus.daddr = 32'h40;
    exp_hit(1'b1, 32'h12345678, cyc + 5);
    exp_acc(1'b0, 32'h40, 32'h0, 4);
    bus.dREN = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (bus.ramREN) chk("ramaddr_hold", bus.ramaddr, 32'h40);
      bus.daddr = 32'h44;
      if (bus.dhit) begin
        bus.dREN = 1'b0;
        break;
      end
    end
    bus.dREN = 1'b0;

    repeat (4) @(negedge CLK);
    chk("hits_left", 32'(hq.size()), 32'd0);
    chk("accesses_left", 32'(aq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
